// File: rtl/calc_entry_fsm.sv
// Operand/operator entry controller for the mini ALU.
// Four raw push-buttons are synchronised, debounced and edge-detected.
// The resulting press events drive an entry FSM: op1 -> op2 -> operation -> result.
//
// Handshake: opValid is a one-cycle, registered strobe with no ready/back-pressure.
// While it is high, op1/op2/operation hold the committed values, and they stay
// stable for the whole RESULT state.
module calc_entry_fsm #(
  parameter int OPW             = 8,
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           btnUp,
  input  logic           btnDown,
  input  logic           btnNext,
  input  logic           btnClr,
  output logic [OPW-1:0] op1,
  output logic [OPW-1:0] op2,
  output logic [1:0]     operation,
  output logic           opValid,
  output logic [1:0]     entryState,
  output logic [OPW-1:0] editValue
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  // Button lane indices inside the 4-bit vectors
  localparam int B_UP   = 0;
  localparam int B_DOWN = 1;
  localparam int B_NEXT = 2;
  localparam int B_CLR  = 3;

  typedef enum logic [1:0] {
    ST_OP1    = 2'd0,
    ST_OP2    = 2'd1,
    ST_OPSEL  = 2'd2,
    ST_RESULT = 2'd3
  } state_t;

  // ---------------- input path ----------------
  logic [3:0]    raw;
  logic [3:0]    sync1_q, sync1_d;
  logic [3:0]    sync2_q, sync2_d;
  logic [3:0]    deb_q, deb_d;
  logic [3:0]    deb_prev_q, deb_prev_d;
  logic [CW-1:0] cnt_q [4];
  logic [CW-1:0] cnt_d [4];
  logic [3:0]    press;

  assign raw = {btnClr, btnNext, btnDown, btnUp};

  // Synchroniser shift and debounce: count cycles in which the synchronised level
  // differs from the accepted level. Accept the new level after DEBOUNCE_CYCLES
  // consecutive differing cycles. Any return to the accepted level restarts the count.
  always_comb begin
    sync1_d    = raw;
    sync2_d    = sync1_q;
    deb_d      = deb_q;
    deb_prev_d = deb_q;
    for (int i = 0; i < 4; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != deb_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          deb_d[i] = sync2_q[i];
          cnt_d[i] = '0;
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
    end
  end

  // A press is a rising edge of the debounced level. A release produces no event.
  assign press = deb_q & ~deb_prev_q;

  // Input-path registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      deb_q      <= '0;
      deb_prev_q <= '0;
      for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      deb_q      <= deb_d;
      deb_prev_q <= deb_prev_d;
      for (int i = 0; i < 4; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  // ---------------- entry FSM ----------------
  state_t         state_q, state_d;
  logic [OPW-1:0] op1_q, op1_d;
  logic [OPW-1:0] op2_q, op2_d;
  logic [1:0]     oper_q, oper_d;
  logic           opvalid_q, opvalid_d;
  logic [OPW-1:0] edit_q, edit_d;
  logic           step_up, step_dn;

  // Up and Down pressed in the same cycle cancel each other
  assign step_up = press[B_UP] & ~press[B_DOWN];
  assign step_dn = press[B_DOWN] & ~press[B_UP];

  // Next-state and field update. Clr beats Next, and Next beats Up/Down.
  always_comb begin
    state_d   = state_q;
    op1_d     = op1_q;
    op2_d     = op2_q;
    oper_d    = oper_q;
    opvalid_d = 1'b0;
    if (press[B_CLR]) begin
      state_d = ST_OP1;
      op1_d   = '0;
      op2_d   = '0;
      oper_d  = '0;
    end else if (press[B_NEXT]) begin
      case (state_q)
        ST_OP1:    state_d = ST_OP2;
        ST_OP2:    state_d = ST_OPSEL;
        ST_OPSEL: begin
          state_d   = ST_RESULT;
          opvalid_d = 1'b1;
        end
        default:   state_d = ST_OP1;
      endcase
    end else begin
      case (state_q)
        ST_OP1: begin
          if (step_up)      op1_d = op1_q + OPW'(1);
          else if (step_dn) op1_d = op1_q - OPW'(1);
        end
        ST_OP2: begin
          if (step_up)      op2_d = op2_q + OPW'(1);
          else if (step_dn) op2_d = op2_q - OPW'(1);
        end
        ST_OPSEL: begin
          if (step_up)      oper_d = oper_q + 2'd1;
          else if (step_dn) oper_d = oper_q - 2'd1;
        end
        default: ;
      endcase
    end
  end

  // Display field follows the next state, so it updates on the same edge as its source
  always_comb begin
    edit_d = '0;
    case (state_d)
      ST_OP1:   edit_d = op1_d;
      ST_OP2:   edit_d = op2_d;
      ST_OPSEL: edit_d = OPW'(oper_d);
      default:  edit_d = '0;
    endcase
  end

  // FSM and output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_OP1;
      op1_q     <= '0;
      op2_q     <= '0;
      oper_q    <= '0;
      opvalid_q <= 1'b0;
      edit_q    <= '0;
    end else begin
      state_q   <= state_d;
      op1_q     <= op1_d;
      op2_q     <= op2_d;
      oper_q    <= oper_d;
      opvalid_q <= opvalid_d;
      edit_q    <= edit_d;
    end
  end

  assign op1        = op1_q;
  assign op2        = op2_q;
  assign operation  = oper_q;
  assign opValid    = opvalid_q;
  assign entryState = state_q;
  assign editValue  = edit_q;

endmodule

// File: tb/tb_calc_entry_fsm.sv
// Testbench for calc_entry_fsm with DEBOUNCE_CYCLES=4 and OPW=8.
module tb_calc_entry_fsm;

  logic       clk;
  logic       rst_n;
  logic       btnUp, btnDown, btnNext, btnClr;
  logic [7:0] op1, op2, editValue;
  logic [1:0] operation, entryState;
  logic       opValid;

  int checks   = 0;
  int failures = 0;

  // Button masks: {clr, next, down, up}
  localparam logic [3:0] M_UP   = 4'b0001;
  localparam logic [3:0] M_DN   = 4'b0010;
  localparam logic [3:0] M_UPDN = 4'b0011;
  localparam logic [3:0] M_NX   = 4'b0100;
  localparam logic [3:0] M_CLNX = 4'b1100;

  typedef struct {
    logic [3:0] btn;
    int         rpt;
    logic [1:0] st;
    logic [7:0] op1;
    logic [7:0] op2;
    logic [1:0] oper;
    logic [7:0] edit;
  } vec_t;

  vec_t vecs[10];

  calc_entry_fsm #(.OPW(8), .DEBOUNCE_CYCLES(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .btnUp      (btnUp),
    .btnDown    (btnDown),
    .btnNext    (btnNext),
    .btnClr     (btnClr),
    .op1        (op1),
    .op2        (op2),
    .operation  (operation),
    .opValid    (opValid),
    .entryState (entryState),
    .editValue  (editValue)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard helpers ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string nm, input logic [1:0] st, input logic [7:0] e1,
                         input logic [7:0] e2, input logic [1:0] eo, input logic [7:0] ed);
    chk({nm, ".state"}, 32'(entryState), 32'(st));
    chk({nm, ".op1"}, 32'(op1), 32'(e1));
    chk({nm, ".op2"}, 32'(op2), 32'(e2));
    chk({nm, ".operation"}, 32'(operation), 32'(eo));
    chk({nm, ".edit"}, 32'(editValue), 32'(ed));
    chk({nm, ".opValid"}, 32'(opValid), 32'd0);
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_btn(input logic [3:0] m);
    {btnClr, btnNext, btnDown, btnUp} = m;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    set_btn(4'b0000);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Hold the mask for 8 cycles, then release for 8 cycles. Count opValid pulses
  // and snapshot the outputs on the cycle opValid is seen.
  task automatic press_mon(input logic [3:0] m, output int nv, output logic [7:0] s1,
                           output logic [7:0] s2, output logic [1:0] so,
                           output logic [1:0] ss, output logic [7:0] se);
    nv = 0; s1 = '0; s2 = '0; so = '0; ss = '0; se = '0;
    @(negedge clk);
    set_btn(m);
    for (int c = 0; c < 16; c++) begin
      if (c == 8) set_btn(4'b0000);
      @(negedge clk);
      if (opValid) begin
        nv++;
        s1 = op1; s2 = op2; so = operation; ss = entryState; se = editValue;
      end
    end
  endtask

  task automatic press(input logic [3:0] m);
    int nv;
    logic [7:0] a, b, e;
    logic [1:0] o, s;
    press_mon(m, nv, a, b, o, s, e);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int nv, lat, nchg;
    logic [7:0] s1, s2, se, prev;
    logic [1:0] so, ss;

    rst_n = 1'b1;
    set_btn(4'b0000);

    // Reset state
    do_reset();
    chk_all("reset", 2'd0, 8'd0, 8'd0, 2'd0, 8'd0);

    // Glitch of 3 cycles must not register
    @(negedge clk);
    btnUp = 1'b1;
    repeat (3) @(negedge clk);
    btnUp = 1'b0;
    repeat (15) @(negedge clk);
    chk("glitch.op1", 32'(op1), 32'd0);

    // Held 12 cycles: exactly one increment, 7 edges after the raw rise
    @(negedge clk);
    btnUp = 1'b1;
    lat = 99;
    nchg = 0;
    prev = op1;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk);
      #1;
      if (op1 !== prev) begin
        nchg++;
        if (lat == 99) lat = k;
        prev = op1;
      end
    end
    chk("latency.edges", 32'(lat), 32'd7);
    chk("latency.changes", 32'(nchg), 32'd1);
    btnUp = 1'b0;
    repeat (12) @(negedge clk);
    chk("release.op1", 32'(op1), 32'd1);

    // Table-driven: wrap and the entry part of the full flow
    vecs[0] = '{M_DN,   3, 2'd0, 8'd253, 8'd0, 2'd0, 8'd253};
    vecs[1] = '{M_UP,   3, 2'd0, 8'd0,   8'd0, 2'd0, 8'd0};
    vecs[2] = '{M_UP,   5, 2'd0, 8'd5,   8'd0, 2'd0, 8'd5};
    vecs[3] = '{M_NX,   1, 2'd1, 8'd5,   8'd0, 2'd0, 8'd0};
    vecs[4] = '{M_UP,   3, 2'd1, 8'd5,   8'd3, 2'd0, 8'd3};
    vecs[5] = '{M_NX,   1, 2'd2, 8'd5,   8'd3, 2'd0, 8'd0};
    vecs[6] = '{M_DN,   1, 2'd2, 8'd5,   8'd3, 2'd3, 8'd3};
    vecs[7] = '{M_UP,   1, 2'd2, 8'd5,   8'd3, 2'd0, 8'd0};
    vecs[8] = '{M_UP,   2, 2'd2, 8'd5,   8'd3, 2'd2, 8'd2};
    vecs[9] = '{M_UPDN, 1, 2'd2, 8'd5,   8'd3, 2'd2, 8'd2};

    do_reset();
    for (int v = 0; v < 10; v++) begin
      for (int r = 0; r < vecs[v].rpt; r++) press(vecs[v].btn);
      chk_all($sformatf("vec%0d", v), vecs[v].st, vecs[v].op1, vecs[v].op2,
              vecs[v].oper, vecs[v].edit);
    end

    // Commit: opValid exactly one cycle, with committed values
    press_mon(M_NX, nv, s1, s2, so, ss, se);
    chk("commit.pulses", 32'(nv), 32'd1);
    chk("commit.op1", 32'(s1), 32'd5);
    chk("commit.op2", 32'(s2), 32'd3);
    chk("commit.operation", 32'(so), 32'd2);
    chk("commit.state", 32'(ss), 32'd3);
    chk("commit.edit", 32'(se), 32'd0);

    // Up/Down ignored in RESULT
    press(M_UP);
    chk_all("result_up", 2'd3, 8'd5, 8'd3, 2'd2, 8'd0);

    // Next from RESULT returns to OP1 and keeps the operands
    press_mon(M_NX, nv, s1, s2, so, ss, se);
    chk("wrap.pulses", 32'(nv), 32'd0);
    chk_all("back_op1", 2'd0, 8'd5, 8'd3, 2'd2, 8'd5);

    // Priority: Clr and Next together in OP2 with op2=7
    do_reset();
    press(M_NX);
    for (int r = 0; r < 7; r++) press(M_UP);
    chk_all("pre_clr", 2'd1, 8'd0, 8'd7, 2'd0, 8'd7);
    press(M_UPDN);
    chk_all("op2_updn", 2'd1, 8'd0, 8'd7, 2'd0, 8'd7);
    press_mon(M_CLNX, nv, s1, s2, so, ss, se);
    chk("clr.pulses", 32'(nv), 32'd0);
    chk_all("clr", 2'd0, 8'd0, 8'd0, 2'd0, 8'd0);

    // Reset mid-operation with btnUp partially debounced
    do_reset();
    press(M_UP);
    press(M_NX);
    press(M_UP);
    press(M_NX);
    press(M_UP);
    chk_all("pre_rst", 2'd2, 8'd1, 8'd1, 2'd1, 8'd1);
    @(negedge clk);
    btnUp = 1'b1;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk_all("in_rst", 2'd0, 8'd0, 8'd0, 2'd0, 8'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    btnUp = 1'b0;
    repeat (15) @(negedge clk);
    chk_all("post_rst", 2'd0, 8'd0, 8'd0, 2'd0, 8'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
